// File: rtl/seg_digit_scanner.sv
// Multiplexed hex-digit scanner: holds a display value, scans it digit by digit
// onto a shared nibble bus with one-hot enables, blanking gaps and tear-free loads.
module seg_digit_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic                          blank_lz,
  output logic [3:0]                    digit_nibble,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int unsigned DATA_W     = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX    = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned SCAN_LAST  = SCAN_DIV - 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int unsigned LAST_IDX   = NUM_DIGITS - 1;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     active_q, active_d;
  logic [DATA_W-1:0]     pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;
  logic [NUM_DIGITS-1:0] lz_mask_q, lz_mask_d;

  logic [3:0]            digit_nibble_d;
  logic [NUM_DIGITS-1:0] digit_en_d;
  logic                  frame_tick_d;

  logic slot_adv;
  logic boundary;
  logic accept;
  logic zero_run;
  logic slot_end_d;

  assign load_ready = ~pending_full_q;

  // State, data and registered-output updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= SCAN;
      cnt_q          <= '0;
      idx_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      lz_mask_q      <= '0;
      digit_nibble   <= '0;
      digit_en       <= '0;
      digit_idx      <= '0;
      frame_tick     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      lz_mask_q      <= lz_mask_d;
      digit_nibble   <= digit_nibble_d;
      digit_en       <= digit_en_d;
      digit_idx      <= idx_d;
      frame_tick     <= frame_tick_d;
    end
  end

  // Next-state, handshake and frame-boundary logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CNT_W'(1);
    idx_d          = idx_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    lz_mask_d      = lz_mask_q;
    slot_adv       = 1'b0;
    zero_run       = 1'b1;

    case (state_q)
      SCAN: begin
        if (cnt_q == CNT_W'(SCAN_LAST)) begin
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            slot_adv = 1'b1;
          end
        end
      end
      BLANK: begin
        if (cnt_q == CNT_W'(BLANK_LAST)) begin
          slot_adv = 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase

    if (slot_adv) begin
      state_d = SCAN;
      cnt_d   = '0;
      idx_d   = (idx_q == IDX_W'(LAST_IDX)) ? '0 : idx_q + IDX_W'(1);
    end

    boundary = slot_adv && (idx_q == IDX_W'(LAST_IDX));
    accept   = load_valid && !pending_full_q;

    if (boundary && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end

    // accept and a pending swap cannot coincide: pending_full gates load_ready
    if (accept) begin
      pending_d      = load_data;
      pending_full_d = 1'b1;
    end

    // Leading-zero mask: walk down from the top digit while nibbles stay zero
    if (boundary) begin
      lz_mask_d[0] = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        zero_run     = zero_run && (active_d[4*k +: 4] == 4'h0);
        lz_mask_d[k] = blank_lz && zero_run;
      end
    end
  end

  // Output values for the state being entered, so outputs align with the state
  always_comb begin
    digit_nibble_d = '0;
    digit_en_d     = '0;
    slot_end_d     = 1'b0;

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        digit_nibble_d = active_d[4*k +: 4];
        if (state_d == SCAN && !lz_mask_d[k]) begin
          digit_en_d[k] = 1'b1;
        end
      end
    end

    if (BLANK_CYCLES > 0) begin
      slot_end_d = (state_d == BLANK) && (cnt_d == CNT_W'(BLANK_LAST));
    end else begin
      slot_end_d = (cnt_d == CNT_W'(SCAN_LAST));
    end

    frame_tick_d = slot_end_d && (idx_d == IDX_W'(LAST_IDX));
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner: one instance with blanking gaps and one
// without, both checked every cycle against a phase-derived expectation.
module tb_seg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic        blank_lz;

  logic        load_ready;
  logic [3:0]  digit_nibble;
  logic [3:0]  digit_en;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  logic        load_ready0;
  logic [3:0]  nib0;
  logic [3:0]  en0;
  logic [1:0]  idx0;
  logic        tick0;

  int tests = 0;
  int fails = 0;
  int t     = 0;

  always #5 clk = ~clk;

  seg_digit_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blank_lz(blank_lz), .digit_nibble(digit_nibble),
    .digit_en(digit_en), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  seg_digit_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(1'b0), .load_ready(load_ready0),
    .load_data(16'h0000), .blank_lz(1'b0), .digit_nibble(nib0),
    .digit_en(en0), .digit_idx(idx0), .frame_tick(tick0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic check_reset();
    chk("rst_en", 32'(digit_en), 32'h0);
    chk("rst_nib", 32'(digit_nibble), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_en0", 32'(en0), 32'h0);
    chk("rst_tick0", 32'(tick0), 32'h0);
    chk("rst_ready0", 32'(load_ready0), 32'h1);
  endtask

  // Cycle t=0 is the first cycle after reset (slot 0, count 0).
  // Blanked DUT: 20-cycle frame of 5-cycle slots (4 scan + 1 blank).
  // Unblanked DUT: 16-cycle frame of 4-cycle slots, never all-off.
  task automatic run_cycles(input int n, input logic [15:0] val, input logic [3:0] mask);
    int p;
    int s;
    int w;
    int q;
    logic [3:0] exp_en;
    logic [3:0] exp_nib;
    for (int i = 0; i < n; i++) begin
      tick();
      p = t % 20;
      s = p / 5;
      w = p % 5;
      exp_en  = (w < 4 && !mask[s]) ? (4'b0001 << s) : 4'b0000;
      exp_nib = val[4*s +: 4];
      chk("en", 32'(digit_en), 32'(exp_en));
      chk("nib", 32'(digit_nibble), 32'(exp_nib));
      chk("idx", 32'(digit_idx), 32'(s));
      chk("tick", 32'(frame_tick), (p == 19) ? 32'h1 : 32'h0);
      q = t % 16;
      chk("en0", 32'(en0), 32'(4'b0001 << (q / 4)));
      chk("nib0", 32'(nib0), 32'h0);
      chk("idx0", 32'(idx0), 32'(q / 4));
      chk("tick0", 32'(tick0), (q == 15) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank_lz   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    t     = 0;

    // Idle scan: two frames of zeros
    run_cycles(40, 16'h0000, 4'b0000);

    // Mid-frame load: held until the frame boundary at t=59
    run_cycles(5, 16'h0000, 4'b0000);
    load_valid = 1'b1;
    load_data  = 16'h1A3F;
    chk("ready_before_load", 32'(load_ready), 32'h1);
    run_cycles(1, 16'h0000, 4'b0000);
    chk("ready_drop", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    load_data  = 16'hDEAD;
    run_cycles(13, 16'h0000, 4'b0000);
    chk("ready_at_tick", 32'(load_ready), 32'h0);
    run_cycles(1, 16'h1A3F, 4'b0000);
    chk("ready_after_tick", 32'(load_ready), 32'h1);
    run_cycles(19, 16'h1A3F, 4'b0000);

    // Back-to-back loads: second stalls behind the first
    run_cycles(3, 16'h1A3F, 4'b0000);
    load_valid = 1'b1;
    load_data  = 16'h1111;
    run_cycles(1, 16'h1A3F, 4'b0000);
    chk("b2b_ready0", 32'(load_ready), 32'h0);
    load_data = 16'h2222;
    run_cycles(16, 16'h1A3F, 4'b0000);
    chk("b2b_stall", 32'(load_ready), 32'h0);
    run_cycles(1, 16'h1111, 4'b0000);
    chk("b2b_ready1", 32'(load_ready), 32'h1);
    run_cycles(1, 16'h1111, 4'b0000);
    chk("b2b_second_acc", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    run_cycles(18, 16'h1111, 4'b0000);
    run_cycles(20, 16'h2222, 4'b0000);

    // Accept in the boundary cycle lands in pending for the next frame
    load_valid = 1'b1;
    load_data  = 16'h0050;
    blank_lz   = 1'b1;
    run_cycles(1, 16'h2222, 4'b0000);
    chk("bnd_accept", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    run_cycles(19, 16'h2222, 4'b0000);
    run_cycles(6, 16'h0050, 4'b1100);
    load_valid = 1'b1;
    load_data  = 16'h0000;
    run_cycles(1, 16'h0050, 4'b1100);
    load_valid = 1'b0;
    run_cycles(13, 16'h0050, 4'b1100);
    run_cycles(6, 16'h0000, 4'b1110);
    blank_lz = 1'b0;
    run_cycles(14, 16'h0000, 4'b1110);
    run_cycles(20, 16'h0000, 4'b0000);

    // Mid-slot reset discards a pending value
    run_cycles(3, 16'h0000, 4'b0000);
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    run_cycles(1, 16'h0000, 4'b0000);
    chk("pend_before_rst", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    run_cycles(4, 16'h0000, 4'b0000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    t     = 0;
    run_cycles(40, 16'h0000, 4'b0000);
    chk("ready_after_rst", 32'(load_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
